md_unit: RTL and testbench

Multiply/divide unit with its own sequencing controller, placed in the E stage beside the ALU. It accepts `mult`/`multu`/`div`/`divu` and `mthi`/`mtlo`/`mfhi`/`mflo`, models fixed multi-cycle latency with a countdown, and owns the HI/LO registers. It feeds `md_out` into the E/M pipeline register and raises the D-stage stall that holds the pipeline while the unit is occupied.

---
 rtl/md_pkg.sv | 30 +++
 rtl/md_calc.sv | 68 ++++++
 rtl/md_unit.sv | 124 ++++++++++++
 tb/tb_md_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   md_op_t      : 4-bit E-stage MD operation encoding (9..15 behave as MD_NONE)
//   md_state_t   : controller state, decoded from the countdown register
//   DEF_MULT_LAT : default busy cycles after a multiply issue
//   DEF_DIV_LAT  : default busy cycles after a divide issue
//   CNT_W        : width of the latency countdown register
package md_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;
   localparam int CNT_W        = 4;

endpackage

// File: rtl/md_calc.sv
// md_calc: purely combinational multiply/divide datapath.
//   op       in  4   MD operation (only mult/multu/div/divu produce results)
//   a, b     in  32  operand A (rs) and operand B (rt)
//   hi, lo   out 32  product {hi,lo}, or remainder (hi) / quotient (lo)
//   div_zero out 1   divide op with b == 0; hi/lo are 0 in that case
module md_calc
   import md_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;

   // Sign-extend to 64 bits so the signed product is computed at full width.
   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed divide is done on magnitudes and re-signed afterwards; this gives
   // truncation toward zero and makes 0x80000000 / -1 wrap to 0x80000000.
   always_comb begin
      a_neg = 1'b0;
      b_neg = 1'b0;
      if (op == MD_DIV) begin
         a_neg = a[31];
         b_neg = b[31];
      end
      a_mag = a_neg ? (~a + 32'd1) : a;
      b_mag = b_neg ? (~b + 32'd1) : b;
      q_mag = 32'd0;
      r_mag = 32'd0;
      if (b_mag != 32'd0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
   end

   always_comb begin
      hi       = 32'd0;
      lo       = 32'd0;
      div_zero = 1'b0;
      case (op)
         MD_MULT:  {hi, lo} = prod_s;
         MD_MULTU: {hi, lo} = prod_u;
         MD_DIV, MD_DIVU: begin
            if (b == 32'd0) begin
               div_zero = 1'b1;
            end else begin
               lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
               hi = a_neg ? (~r_mag + 32'd1) : r_mag;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with fixed-latency countdown and HI/LO.
//   clk         in  1   pipeline clock, rising edge
//   reset       in  1   asynchronous active-low reset
//   in_op       in  4   E-stage MD operation
//   in_rs       in  32  operand A / mthi-mtlo source
//   in_rt       in  32  operand B
//   in_d_is_md  in  1   D-stage instruction is MD-class
//   out_start   out 1   mult/div issuing this cycle (combinational)
//   out_busy    out 1   countdown nonzero (registered)
//   out_stall   out 1   D-stage stall request
//   out_md_out  out 32  HI for mfhi, LO for mflo, else 0
//   out_hi/lo   out 32  architectural HI/LO
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  in_op,
   input  logic [31:0] in_rs,
   input  logic [31:0] in_rt,
   input  logic        in_d_is_md,
   output logic        out_start,
   output logic        out_busy,
   output logic        out_stall,
   output logic [31:0] out_md_out,
   output logic [31:0] out_hi,
   output logic [31:0] out_lo
);

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [31:0]      hi_reg, hi_next;
   logic [31:0]      lo_reg, lo_next;
   logic [31:0]      hi_nxt_reg, hi_nxt_next;
   logic [31:0]      lo_nxt_reg, lo_nxt_next;
   logic             dz_reg, dz_next;

   md_state_t   state;
   logic        is_mult;
   logic        is_div;
   logic [31:0] calc_hi;
   logic [31:0] calc_lo;
   logic        calc_dz;

   md_calc u_calc (
      .op       (in_op),
      .a        (in_rs),
      .b        (in_rt),
      .hi       (calc_hi),
      .lo       (calc_lo),
      .div_zero (calc_dz)
   );

   assign state   = (cnt_reg == '0) ? ST_IDLE : ST_BUSY;
   assign is_mult = (in_op == MD_MULT) || (in_op == MD_MULTU);
   assign is_div  = (in_op == MD_DIV)  || (in_op == MD_DIVU);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg    <= '0;
         hi_reg     <= 32'd0;
         lo_reg     <= 32'd0;
         hi_nxt_reg <= 32'd0;
         lo_nxt_reg <= 32'd0;
         dz_reg     <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
         hi_nxt_reg <= hi_nxt_next;
         lo_nxt_reg <= lo_nxt_next;
         dz_reg     <= dz_next;
      end
   end

   always_comb begin
      cnt_next    = cnt_reg;
      hi_next     = hi_reg;
      lo_next     = lo_reg;
      hi_nxt_next = hi_nxt_reg;
      lo_nxt_next = lo_nxt_reg;
      dz_next     = dz_reg;
      out_start   = 1'b0;
      out_md_out  = 32'd0;
      case (state)
         ST_IDLE: begin
            if (is_mult || is_div) begin
               out_start   = 1'b1;
               hi_nxt_next = calc_hi;
               lo_nxt_next = calc_lo;
               dz_next     = calc_dz;
               cnt_next    = is_mult ? MULT_CNT : DIV_CNT;
            end
            case (in_op)
               MD_MTHI: hi_next    = in_rs;
               MD_MTLO: lo_next    = in_rs;
               MD_MFHI: out_md_out = hi_reg;
               MD_MFLO: out_md_out = lo_reg;
               default: ;
            endcase
         end
         ST_BUSY: begin
            // Incoming ops are ignored here; only the countdown advances.
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CNT_W'(1) && !dz_reg) begin
               hi_next = hi_nxt_reg;
               lo_next = lo_nxt_reg;
            end
         end
         default: ;
      endcase
   end

   assign out_busy  = (state == ST_BUSY);
   assign out_stall = in_d_is_md & (out_start | out_busy);
   assign out_hi    = hi_reg;
   assign out_lo    = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;
   import md_pkg::*;

   logic        clk;
   logic        reset;
   logic [3:0]  in_op;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic        in_d_is_md;
   logic        out_start;
   logic        out_busy;
   logic        out_stall;
   logic [31:0] out_md_out;
   logic [31:0] out_hi;
   logic [31:0] out_lo;

   int n_checks = 0;
   int n_pass   = 0;

   md_unit dut (
      .clk        (clk),
      .reset      (reset),
      .in_op      (in_op),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_d_is_md (in_d_is_md),
      .out_start  (out_start),
      .out_busy   (out_busy),
      .out_stall  (out_stall),
      .out_md_out (out_md_out),
      .out_hi     (out_hi),
      .out_lo     (out_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
      n_checks++;
      if (obs === exp_val) begin
         n_pass++;
         $display("check %-18s got %08h expected %08h ok", tag, obs, exp_val);
      end else begin
         $display("FAIL %-18s got %08h expected %08h", tag, obs, exp_val);
      end
   endtask

   // Issues op in the current cycle, drives inj during every busy cycle,
   // and returns in the first idle cycle with in_op back at MD_NONE.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmd, input logic [3:0] inj,
                         input int lat);
      int n;
      in_op      = op;
      in_rs      = a;
      in_rt      = b;
      in_d_is_md = dmd;
      #1;
      chk({tag, "_start"}, 32'(out_start), 32'd1);
      chk({tag, "_stall0"}, 32'(out_stall), 32'(dmd));
      @(posedge clk); #1;
      in_op = inj;
      in_rs = 32'hDEADBEEF;
      n = 0;
      while (out_busy && n < 20) begin
         #1;
         if (out_stall !== dmd || out_md_out !== 32'd0 || out_start !== 1'b0)
            chk({tag, "_busycyc"}, {out_stall, out_start, 30'd0} | out_md_out,
                {dmd, 31'd0});
         n++;
         @(posedge clk); #1;
      end
      in_op = MD_NONE;
      #1;
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      chk({tag, "_stall_end"}, 32'(out_stall), 32'd0);
   endtask

   initial begin
      reset      = 1'b0;
      in_op      = MD_NONE;
      in_rs      = 32'd0;
      in_rt      = 32'd0;
      in_d_is_md = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(out_busy), 32'd0);
      chk("rst_hi", out_hi, 32'd0);
      chk("rst_lo", out_lo, 32'd0);
      chk("rst_md_out", out_md_out, 32'd0);
      chk("rst_stall", 32'(out_stall), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // signed mult -1 * 2, stall requested by D stage
      run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, MD_NONE, 5);
      chk("mult_hi", out_hi, 32'hFFFFFFFF);
      chk("mult_lo", out_lo, 32'hFFFFFFFE);
      in_op = MD_MFHI; #1;
      chk("mfhi_after_mult", out_md_out, 32'hFFFFFFFF);
      in_op = MD_MFLO; #1;
      chk("mflo_after_mult", out_md_out, 32'hFFFFFFFE);
      in_op = MD_NONE;
      @(posedge clk); #1;

      // unsigned mult, no D-stage MD op; a div injected while busy is ignored
      run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, MD_DIV, 5);
      chk("multu_hi", out_hi, 32'h00000001);
      chk("multu_lo", out_lo, 32'hFFFFFFFE);

      // signed div -7/2; mfhi while busy must read 0
      run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, MD_MFHI, 10);
      chk("div_lo", out_lo, 32'hFFFFFFFD);
      chk("div_hi", out_hi, 32'hFFFFFFFF);

      // divide by zero leaves HI/LO alone
      run_op("divu0", MD_DIVU, 32'd7, 32'd0, 1'b0, MD_NONE, 10);
      chk("divu0_lo", out_lo, 32'hFFFFFFFD);
      chk("divu0_hi", out_hi, 32'hFFFFFFFF);

      // overflow corner
      run_op("divovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, MD_NONE, 10);
      chk("divovf_lo", out_lo, 32'h80000000);
      chk("divovf_hi", out_hi, 32'h00000000);

      // mthi then mfhi next cycle
      in_op = MD_MTHI; in_rs = 32'h00001234; #1;
      chk("mthi_start", 32'(out_start), 32'd0);
      @(posedge clk); #1;
      chk("mthi_busy", 32'(out_busy), 32'd0);
      in_op = MD_MFHI; #1;
      chk("mfhi_after_mthi", out_md_out, 32'h00001234);
      in_op = MD_NONE;
      @(posedge clk); #1;

      // mtlo injected while busy has no effect
      run_op("mult_mtlo", MD_MULT, 32'd3, 32'd4, 1'b1, MD_MTLO, 5);
      chk("mult_mtlo_lo", out_lo, 32'd12);
      chk("mult_mtlo_hi", out_hi, 32'd0);

      // back-to-back: div in the very first idle cycle after a mult
      run_op("b2b_mult", MD_MULTU, 32'd6, 32'd7, 1'b0, MD_NONE, 5);
      chk("b2b_mult_lo", out_lo, 32'd42);
      run_op("b2b_div", MD_DIVU, 32'd100, 32'd7, 1'b0, MD_NONE, 10);
      chk("b2b_div_lo", out_lo, 32'd14);
      chk("b2b_div_hi", out_hi, 32'd2);

      // reset mid-div at cnt=7
      in_op = MD_DIV; in_rs = 32'd50; in_rt = 32'd3; in_d_is_md = 1'b1;
      @(posedge clk); #1;
      in_op = MD_NONE;
      repeat (3) @(posedge clk);
      #1;
      chk("middiv_busy", 32'(out_busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("arst_busy", 32'(out_busy), 32'd0);
      chk("arst_hi", out_hi, 32'd0);
      chk("arst_lo", out_lo, 32'd0);
      chk("arst_stall", 32'(out_stall), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      in_op = MD_MFHI; #1;
      chk("mfhi_after_arst", out_md_out, 32'd0);
      in_op = MD_NONE;
      @(posedge clk); #1;
      chk("post_arst_busy", 32'(out_busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
